// File: rtl/setting_ctrl_param_if.sv
// Bundle of front-panel buttons and committed game settings for the
// buzzer-quiz setting controller.
//   master : drives the buttons, observes the settings (panel / testbench)
//   slave  : the setting controller itself
// Handshake semantics: there is no valid/ready pair here. Every button is a
// level sampled on the rising clock edge, and a press is its rising edge.
// Outputs are registered. endset is a single-cycle pulse that marks a commit.
interface setting_ctrl_param_if #(
  parameter int TIME_W  = 8,
  parameter int SCORE_W = 4
);
  logic               startset;
  logic               btn_next;
  logic               btn_inc;
  logic               btn_dec;
  logic               btn_confirm;
  logic               btn_cancel;
  logic [TIME_W-1:0]  maxtime;
  logic [3:0]         maxuser;
  logic [SCORE_W-1:0] scoreadd;
  logic [SCORE_W-1:0] scoresubtract;
  logic               editing;
  logic [1:0]         sel_field;
  logic [TIME_W-1:0]  edit_value;
  logic               endset;
  logic               state_dbg;  // raw FSM state: 0 idle, 1 edit

  modport master (
    output startset, btn_next, btn_inc, btn_dec, btn_confirm, btn_cancel,
    input  maxtime, maxuser, scoreadd, scoresubtract, editing, sel_field,
           edit_value, endset, state_dbg
  );

  modport slave (
    input  startset, btn_next, btn_inc, btn_dec, btn_confirm, btn_cancel,
    output maxtime, maxuser, scoreadd, scoresubtract, editing, sel_field,
           edit_value, endset, state_dbg
  );
endinterface

// File: rtl/setting_ctrl_param.sv
// Game-setting controller for the buzzer-quiz system.
// The front-panel buttons edit four fields in shadow registers: answer time,
// player count, add step and subtract step. Confirm copies the shadows to the
// committed outputs and cancel discards them. The controller supports field
// select, min/max limits, saturate or wrap at the limits, and hold-to-repeat
// on inc/dec.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : setting_ctrl_param_if.slave
//                (buttons in; committed settings, edit status and endset out)
module setting_ctrl_param #(
  parameter int TIME_W    = 8,
  parameter int TIME_MIN  = 5,
  parameter int TIME_MAX  = 99,
  parameter int TIME_STEP = 5,
  parameter int TIME_DEF  = 30,
  parameter int USER_MAX  = 8,
  parameter int SCORE_W   = 4,
  parameter int SCORE_MAX = 9,
  parameter int WRAP      = 0,
  parameter int HOLD_CYC  = 1000,
  parameter int REP_CYC   = 250
) (
  input  logic                 clk,
  input  logic                 rst_n,
  setting_ctrl_param_if.slave  bus
);
  // Step arithmetic is one bit wider than the widest field, so v+step never
  // overflows before it is compared against the limit.
  localparam int AW      = TIME_W + 1;
  localparam int CNT_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam int B_START   = 0;
  localparam int B_NEXT    = 1;
  localparam int B_INC     = 2;
  localparam int B_DEC     = 3;
  localparam int B_CONFIRM = 4;
  localparam int B_CANCEL  = 5;

  typedef enum logic {IDLE = 1'b0, EDIT = 1'b1} state_t;
  state_t state, state_nxt;

  logic [5:0] btn_cur, btn_prev, btn_ev;

  logic [TIME_W-1:0]  maxtime_q, sh_time;
  logic [3:0]         maxuser_q, sh_user;
  logic [SCORE_W-1:0] scoreadd_q, scoresub_q, sh_add, sh_sub;
  logic [1:0]         sel_q, sel_nxt;
  logic               endset_q;
  logic [TIME_W-1:0]  edit_value_q;

  // Auto-repeat bookkeeping:
  //   rep_act : a single-direction press is being tracked
  //   rep_on  : the initial hold delay has elapsed
  //   rep_dir : 1 for inc, 0 for dec
  logic             rep_act, rep_act_nxt, rep_on, rep_on_nxt, rep_dir, rep_dir_nxt;
  logic [CNT_W-1:0] rep_cnt, rep_cnt_nxt;

  logic load, commit, step_req, step_up, clr_rep, single;

  logic [AW-1:0]     fv, fmin, fmax, fstep, up_sum;
  logic [TIME_W-1:0] step_res;

  assign btn_cur = {bus.btn_cancel, bus.btn_confirm, bus.btn_dec,
                    bus.btn_inc, bus.btn_next, bus.startset};
  assign btn_ev  = btn_cur & ~btn_prev;
  assign single  = btn_cur[B_INC] ^ btn_cur[B_DEC];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and control decode.
  // Priority in EDIT is cancel > confirm > next > inc/dec.
  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    commit      = 1'b0;
    step_req    = 1'b0;
    step_up     = btn_cur[B_INC];
    clr_rep     = 1'b0;
    sel_nxt     = sel_q;
    rep_act_nxt = rep_act;
    rep_on_nxt  = rep_on;
    rep_dir_nxt = rep_dir;
    rep_cnt_nxt = rep_cnt;
    case (state)
      IDLE: begin
        clr_rep = 1'b1;
        if (btn_ev[B_START]) begin
          state_nxt = EDIT;
          load      = 1'b1;
          sel_nxt   = 2'd0;
        end
      end
      EDIT: begin
        if (btn_ev[B_CANCEL]) begin
          state_nxt = IDLE;
          clr_rep   = 1'b1;
        end else if (btn_ev[B_CONFIRM]) begin
          state_nxt = IDLE;
          commit    = 1'b1;
          clr_rep   = 1'b1;
        end else if (btn_ev[B_NEXT]) begin
          sel_nxt = sel_q + 2'd1;
          clr_rep = 1'b1;
        end else if (single) begin
          if (btn_ev[B_INC] || btn_ev[B_DEC]) begin
            // Fresh press of one direction: step now and start the hold timer.
            step_req    = 1'b1;
            rep_act_nxt = 1'b1;
            rep_on_nxt  = 1'b0;
            rep_dir_nxt = step_up;
            rep_cnt_nxt = '0;
          end else if (rep_act && (rep_dir == step_up)) begin
            if (!rep_on) begin
              if (rep_cnt == CNT_W'(HOLD_CYC - 1)) begin
                step_req    = 1'b1;
                rep_on_nxt  = 1'b1;
                rep_cnt_nxt = '0;
              end else begin
                rep_cnt_nxt = rep_cnt + 1'b1;
              end
            end else if (rep_cnt == CNT_W'(REP_CYC - 1)) begin
              step_req    = 1'b1;
              rep_cnt_nxt = '0;
            end else begin
              rep_cnt_nxt = rep_cnt + 1'b1;
            end
          end else begin
            // Held without a tracked press (e.g. held before EDIT) or direction swapped.
            clr_rep = 1'b1;
          end
        end else begin
          clr_rep = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (clr_rep) begin
      rep_act_nxt = 1'b0;
      rep_on_nxt  = 1'b0;
      rep_cnt_nxt = '0;
    end
  end

  // Selected field value, its limits, and the result of one step
  always_comb begin
    fv    = '0;
    fmin  = '0;
    fmax  = '0;
    fstep = '0;
    case (sel_q)
      2'd0: begin
        fv = AW'(sh_time); fmin = AW'(TIME_MIN); fmax = AW'(TIME_MAX); fstep = AW'(TIME_STEP);
      end
      2'd1: begin
        fv = AW'(sh_user); fmin = AW'(2); fmax = AW'(USER_MAX); fstep = AW'(1);
      end
      2'd2: begin
        fv = AW'(sh_add); fmin = AW'(1); fmax = AW'(SCORE_MAX); fstep = AW'(1);
      end
      default: begin
        fv = AW'(sh_sub); fmin = AW'(1); fmax = AW'(SCORE_MAX); fstep = AW'(1);
      end
    endcase
    up_sum   = fv + fstep;
    step_res = TIME_W'(fv);
    if (step_up) begin
      if (up_sum > fmax) step_res = (WRAP != 0) ? TIME_W'(fmin) : TIME_W'(fmax);
      else               step_res = TIME_W'(up_sum);
    end else begin
      // Compare against min+step rather than subtracting, so there is no underflow.
      if (fv < fmin + fstep) step_res = (WRAP != 0) ? TIME_W'(fmax) : TIME_W'(fmin);
      else                   step_res = TIME_W'(fv - fstep);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev     <= '0;
      maxtime_q    <= TIME_W'(TIME_DEF);
      maxuser_q    <= 4'(USER_MAX);
      scoreadd_q   <= SCORE_W'(1);
      scoresub_q   <= SCORE_W'(1);
      sh_time      <= TIME_W'(TIME_DEF);
      sh_user      <= 4'(USER_MAX);
      sh_add       <= SCORE_W'(1);
      sh_sub       <= SCORE_W'(1);
      sel_q        <= 2'd0;
      endset_q     <= 1'b0;
      edit_value_q <= '0;
      rep_act      <= 1'b0;
      rep_on       <= 1'b0;
      rep_dir      <= 1'b0;
      rep_cnt      <= '0;
    end else begin
      btn_prev <= btn_cur;
      sel_q    <= sel_nxt;
      endset_q <= commit;
      rep_act  <= rep_act_nxt;
      rep_on   <= rep_on_nxt;
      rep_dir  <= rep_dir_nxt;
      rep_cnt  <= rep_cnt_nxt;
      if (load) begin
        sh_time <= maxtime_q;
        sh_user <= maxuser_q;
        sh_add  <= scoreadd_q;
        sh_sub  <= scoresub_q;
      end else if (step_req) begin
        case (sel_q)
          2'd0:    sh_time <= step_res;
          2'd1:    sh_user <= step_res[3:0];
          2'd2:    sh_add  <= step_res[SCORE_W-1:0];
          default: sh_sub  <= step_res[SCORE_W-1:0];
        endcase
      end
      if (commit) begin
        maxtime_q  <= sh_time;
        maxuser_q  <= sh_user;
        scoreadd_q <= sh_add;
        scoresub_q <= sh_sub;
      end
      edit_value_q <= (state == EDIT) ? fv[TIME_W-1:0] : '0;
    end
  end

  assign bus.maxtime       = maxtime_q;
  assign bus.maxuser       = maxuser_q;
  assign bus.scoreadd      = scoreadd_q;
  assign bus.scoresubtract = scoresub_q;
  assign bus.editing       = (state == EDIT);
  assign bus.sel_field     = sel_q;
  assign bus.edit_value    = edit_value_q;
  assign bus.endset        = endset_q;
  assign bus.state_dbg     = (state == EDIT);
endmodule

// File: tb/tb_setting_ctrl_param.sv
module tb_setting_ctrl_param;
  localparam int TIME_W    = 8;
  localparam int SCORE_W   = 4;
  localparam int TIME_MIN  = 5;
  localparam int TIME_MAX  = 99;
  localparam int TIME_STEP = 5;
  localparam int TIME_DEF  = 30;
  localparam int USER_MAX  = 8;
  localparam int SCORE_MAX = 9;
  localparam int HOLD      = 20;
  localparam int REP       = 5;

  localparam int B_START   = 0;
  localparam int B_NEXT    = 1;
  localparam int B_INC     = 2;
  localparam int B_DEC     = 3;
  localparam int B_CONFIRM = 4;
  localparam int B_CANCEL  = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] btn = '0;

  setting_ctrl_param_if #(.TIME_W(TIME_W), .SCORE_W(SCORE_W)) bus0 ();
  setting_ctrl_param_if #(.TIME_W(TIME_W), .SCORE_W(SCORE_W)) bus1 ();

  assign bus0.startset    = btn[B_START];
  assign bus0.btn_next    = btn[B_NEXT];
  assign bus0.btn_inc     = btn[B_INC];
  assign bus0.btn_dec     = btn[B_DEC];
  assign bus0.btn_confirm = btn[B_CONFIRM];
  assign bus0.btn_cancel  = btn[B_CANCEL];
  assign bus1.startset    = btn[B_START];
  assign bus1.btn_next    = btn[B_NEXT];
  assign bus1.btn_inc     = btn[B_INC];
  assign bus1.btn_dec     = btn[B_DEC];
  assign bus1.btn_confirm = btn[B_CONFIRM];
  assign bus1.btn_cancel  = btn[B_CANCEL];

  setting_ctrl_param #(.WRAP(0), .HOLD_CYC(HOLD), .REP_CYC(REP)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  setting_ctrl_param #(.WRAP(1), .HOLD_CYC(HOLD), .REP_CYC(REP)) u_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  // ---------------- reference model ----------------
  // Index [0] models the saturating instance and [1] the wrapping one.
  // Fields: 0 time, 1 user, 2 add, 3 subtract.
  int m_com[2][4];
  int m_sh[2][4];
  int m_sel;
  bit m_edit;

  function automatic int f_min(int f);
    if (f == 0) return TIME_MIN;
    if (f == 1) return 2;
    return 1;
  endfunction

  function automatic int f_max(int f);
    if (f == 0) return TIME_MAX;
    if (f == 1) return USER_MAX;
    return SCORE_MAX;
  endfunction

  function automatic int step_val(int v, int f, bit up, bit wrap);
    int n;
    int st;
    st = (f == 0) ? TIME_STEP : 1;
    n  = up ? v + st : v - st;
    if (n > f_max(f)) return wrap ? f_min(f) : f_max(f);
    if (n < f_min(f)) return wrap ? f_max(f) : f_min(f);
    return n;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_com[w] = '{TIME_DEF, USER_MAX, 1, 1};
      m_sh[w]  = '{TIME_DEF, USER_MAX, 1, 1};
    end
    m_sel  = 0;
    m_edit = 1'b0;
  endtask

  task automatic model_events(input logic [5:0] m, output bit c);
    c = 1'b0;
    if (!m_edit) begin
      if (m[B_START]) begin
        m_edit = 1'b1;
        m_sel  = 0;
        for (int w = 0; w < 2; w++) m_sh[w] = m_com[w];
      end
    end else if (m[B_CANCEL]) begin
      m_edit = 1'b0;
    end else if (m[B_CONFIRM]) begin
      for (int w = 0; w < 2; w++) m_com[w] = m_sh[w];
      m_edit = 1'b0;
      c      = 1'b1;
    end else if (m[B_NEXT]) begin
      m_sel = (m_sel + 1) % 4;
    end else if (m[B_INC] ^ m[B_DEC]) begin
      for (int w = 0; w < 2; w++)
        m_sh[w][m_sel] = step_val(m_sh[w][m_sel], m_sel, m[B_INC], w == 1);
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_maxtime_sat"},  bus0.maxtime,       m_com[0][0]);
    check({tag, "_maxuser_sat"},  bus0.maxuser,       m_com[0][1]);
    check({tag, "_add_sat"},      bus0.scoreadd,      m_com[0][2]);
    check({tag, "_sub_sat"},      bus0.scoresubtract, m_com[0][3]);
    check({tag, "_edit_sat"},     bus0.editing,       m_edit);
    check({tag, "_sel_sat"},      bus0.sel_field,     m_sel);
    check({tag, "_value_sat"},    bus0.edit_value,    m_edit ? m_sh[0][m_sel] : 0);
    check({tag, "_maxtime_wrap"}, bus1.maxtime,       m_com[1][0]);
    check({tag, "_maxuser_wrap"}, bus1.maxuser,       m_com[1][1]);
    check({tag, "_add_wrap"},     bus1.scoreadd,      m_com[1][2]);
    check({tag, "_sub_wrap"},     bus1.scoresubtract, m_com[1][3]);
    check({tag, "_edit_wrap"},    bus1.editing,       m_edit);
    check({tag, "_sel_wrap"},     bus1.sel_field,     m_sel);
    check({tag, "_value_wrap"},   bus1.edit_value,    m_edit ? m_sh[1][m_sel] : 0);
  endtask

  // ---------------- driver tasks ----------------
  // One-cycle press of every button in m together, then a release cycle.
  // endset is sampled the cycle after the press edge (commit pulse) and once more.
  task automatic press(input string tag, input logic [5:0] m);
    bit         c;
    logic       s0a, s1a, s0b, s1b;
    logic [0:0] e;
    model_events(m, c);
    @(negedge clk) btn = m;
    @(negedge clk) btn = '0;
    s0a = bus0.endset;
    s1a = bus1.endset;
    @(negedge clk);
    s0b = bus0.endset;
    s1b = bus1.endset;
    exp_q.push_back(c);
    exp_q.push_back(1'b0);
    e = exp_q.pop_front();
    check({tag, "_endset_sat"},  s0a, e);
    check({tag, "_endset_wrap"}, s1a, e);
    e = exp_q.pop_front();
    check({tag, "_endset2_sat"},  s0b, e);
    check({tag, "_endset2_wrap"}, s1b, e);
    check_all(tag);
  endtask

  // Hold inc (up=1) or dec for n sampled edges. Steps happen on the press edge,
  // HOLD edges later, and every REP edges after that.
  task automatic hold(input string tag, input bit up, input int n);
    int steps;
    steps = 1 + ((n - 1 >= HOLD) ? 1 + (n - 1 - HOLD) / REP : 0);
    if (m_edit)
      for (int w = 0; w < 2; w++)
        for (int k = 0; k < steps; k++)
          m_sh[w][m_sel] = step_val(m_sh[w][m_sel], m_sel, up, w == 1);
    @(negedge clk) btn = up ? 6'(1 << B_INC) : 6'(1 << B_DEC);
    repeat (n) @(posedge clk);
    @(negedge clk) btn = '0;
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    btn   = '0;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    @(negedge clk) rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Edit time twice and commit.
    press("t2_start", 6'(1 << B_START));
    press("t2_inc1", 6'(1 << B_INC));
    press("t2_inc2", 6'(1 << B_INC));
    press("t2_confirm", 6'(1 << B_CONFIRM));
    check("t2_maxtime_40", bus0.maxtime, 40);

    // Edit the player count, then cancel.
    press("t3_start", 6'(1 << B_START));
    press("t3_next", 6'(1 << B_NEXT));
    for (int i = 0; i < 3; i++) press("t3_dec", 6'(1 << B_DEC));
    check("t3_user_5", bus0.edit_value, 5);
    press("t3_cancel", 6'(1 << B_CANCEL));
    check("t3_maxuser_8", bus0.maxuser, 8);

    // Limits: time 40 -> 95 -> over the top; user down to 2 -> below.
    press("t4_start", 6'(1 << B_START));
    for (int i = 0; i < 11; i++) press("t4_inc", 6'(1 << B_INC));
    check("t4_time_95", bus0.edit_value, 95);
    press("t4_over", 6'(1 << B_INC));
    check("t4_sat_99", bus0.edit_value, 99);
    check("t4_wrap_5", bus1.edit_value, 5);
    press("t4_next", 6'(1 << B_NEXT));
    for (int i = 0; i < 6; i++) press("t4_dec", 6'(1 << B_DEC));
    press("t4_under", 6'(1 << B_DEC));
    check("t4_sat_2", bus0.edit_value, 2);
    check("t4_wrap_8", bus1.edit_value, 8);
    press("t4_cancel", 6'(1 << B_CANCEL));

    // Hold-to-repeat on the add field: 1 + edge step + 3 repeats = 5.
    press("t5_start", 6'(1 << B_START));
    press("t5_next1", 6'(1 << B_NEXT));
    press("t5_next2", 6'(1 << B_NEXT));
    hold("t5_hold", 1'b1, HOLD + 2 * REP + 1);
    check("t5_add_5", bus0.edit_value, 5);

    // Conflicts.
    press("t6_incdec", 6'((1 << B_INC) | (1 << B_DEC)));
    check("t6_add_still_5", bus0.edit_value, 5);
    press("t6_conf_canc", 6'((1 << B_CONFIRM) | (1 << B_CANCEL)));
    check("t6_add_uncommitted", bus0.scoreadd, 1);

    // Reset while editing.
    press("t1_start", 6'(1 << B_START));
    press("t1_inc", 6'(1 << B_INC));
    do_reset("t1_reset");

    // Randomized mix.
    for (int it = 0; it < 150; it++) begin
      int r;
      r = $urandom_range(0, 11);
      if (!m_edit && $urandom_range(0, 2) == 0) r = 0;
      case (r)
        0:       press("rnd_start", 6'(1 << B_START));
        1:       press("rnd_next", 6'(1 << B_NEXT));
        2, 3:    press("rnd_inc", 6'(1 << B_INC));
        4, 5:    press("rnd_dec", 6'(1 << B_DEC));
        6:       press("rnd_confirm", 6'(1 << B_CONFIRM));
        7:       press("rnd_cancel", 6'(1 << B_CANCEL));
        8:       press("rnd_incdec", 6'((1 << B_INC) | (1 << B_DEC)));
        9:       press("rnd_mask", 6'($urandom_range(0, 63)));
        10:      hold("rnd_hold", 1'($urandom_range(0, 1)), $urandom_range(1, HOLD + 4 * REP));
        default: if ($urandom_range(0, 9) == 0) do_reset("rnd_reset");
                 else press("rnd_confirm2", 6'(1 << B_CONFIRM));
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
